// File: rtl/fft_pkg.sv
// Shared constants, state type and index helpers for the FFT frame unloader.
package fft_pkg;

    localparam int N_PTS = 32;
    localparam int SMP_W = 64;
    localparam int LOG2N = $clog2(N_PTS);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Reverses the bit order of an LOG2N-bit sample index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[LOG2N-1-b] = idx[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_unloader.sv
// Captures a full FFT output frame and streams it one sample per cycle (valid/ready).
// Build option: FFT_UNLOAD_BITREV_EN reorders a bit-reversed frame into natural order.
module fft_frame_unloader
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_valid,
    input  logic [N_PTS*SMP_W-1:0]   frame_data,
    output logic                     frame_ready,
    output logic                     smp_valid,
    input  logic                     smp_ready,
    output logic [SMP_W-1:0]         smp_data,
    output logic [LOG2N-1:0]         smp_index,
    output logic                     smp_last,
    output logic [15:0]              frame_cnt
);

    state_t                   state_reg, state_next;
    logic [LOG2N-1:0]         cnt_reg, cnt_next;
    logic [N_PTS*SMP_W-1:0]   frame_reg;
    logic [15:0]              frame_cnt_reg, frame_cnt_next;
    logic [LOG2N-1:0]         sel;
    logic                     xfer;
    logic                     accept;
    logic                     at_last;

`ifdef FFT_UNLOAD_BITREV_EN
    assign sel = bitrev(cnt_reg);
`else
    assign sel = cnt_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        at_last        = (state_reg == STREAM) && (cnt_reg == LOG2N'(N_PTS-1));
        xfer           = (state_reg == STREAM) && smp_ready;
        // Ready must never look at frame_valid, so the upstream can rely on it combinationally.
        frame_ready    = (state_reg == IDLE) || (at_last && smp_ready);
        accept         = frame_valid && frame_ready;

        case (state_reg)
            IDLE: begin
                if (frame_valid) begin
                    state_next = STREAM;
                    cnt_next   = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (at_last) begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                        if (frame_valid) begin
                            cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            frame_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            if (accept) begin
                frame_reg <= frame_data;
            end
        end
    end

    assign smp_valid = (state_reg == STREAM);
    assign smp_index = cnt_reg;
    assign smp_last  = at_last;
    assign smp_data  = frame_reg[int'(sel)*SMP_W +: SMP_W];
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Self-checking bench for fft_frame_unloader; honours FFT_UNLOAD_BITREV_EN the same way as the DUT.
module tb_fft_frame_unloader;

    localparam int N  = 32;
    localparam int W  = 64;
    localparam int FW = N*W;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_valid;
    logic [FW-1:0] frame_data;
    logic          frame_ready;
    logic          smp_valid;
    logic          smp_ready;
    logic [W-1:0]  smp_data;
    logic [4:0]    smp_index;
    logic          smp_last;
    logic [15:0]   frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;

    logic [FW-1:0] f_a, f_b, f_c;

    fft_frame_unloader dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .smp_data    (smp_data),
        .smp_index   (smp_index),
        .smp_last    (smp_last),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // Expected sample at output position p: natural order, or bit-reversed source when enabled.
    function automatic logic [W-1:0] exp_at(input logic [FW-1:0] f, input int p);
        int src;
        src = p;
`ifdef FFT_UNLOAD_BITREV_EN
        src = 0;
        for (int b = 0; b < 5; b++) begin
            if (p[b]) src = src | (1 << (4 - b));
        end
`endif
        return f[W*src +: W];
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < N; k++) begin
            f[W*k +: W] = {$urandom(), $urandom()};
        end
        return f;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_valid"}, W'(smp_valid), W'(1'b0));
        check({tag, "_fready"}, W'(frame_ready), W'(1'b1));
        check({tag, "_last"}, W'(smp_last), W'(1'b0));
        check({tag, "_fcnt"}, W'(frame_cnt), W'(exp_fc));
    endtask

    task automatic load(input logic [FW-1:0] f);
        frame_valid = 1'b1;
        frame_data  = f;
        smp_ready   = 1'($urandom_range(0, 1));
        #1;
        check("load_fready", W'(frame_ready), W'(1'b1));
        step();
        frame_valid = 1'b0;
        frame_data  = rand_frame();
    endtask

    // Streams one whole frame through, checking every cycle. toggle: ready pattern 1,0,0,1.
    // chain: offer nf on the last transfer. inject_at: offer junk frame while at that position.
    task automatic xfer_frame(input logic [FW-1:0] f, input bit toggle, input bit chain,
                              input logic [FW-1:0] nf, input int inject_at);
        int  pos;
        int  ph;
        int  lasts;
        logic sr;
        pos   = 0;
        ph    = 0;
        lasts = 0;
        while (pos < N) begin
            sr = toggle ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ph++;
            frame_valid = 1'b0;
            if (pos == inject_at) begin
                frame_valid = 1'b1;
                frame_data  = rand_frame();
            end
            if (chain && pos == N-1 && sr) begin
                frame_valid = 1'b1;
                frame_data  = nf;
            end
            smp_ready = sr;
            #1;
            check("valid", W'(smp_valid), W'(1'b1));
            check("index", W'(smp_index), W'(pos));
            check("data", smp_data, exp_at(f, pos));
            check("last", W'(smp_last), W'(pos == N-1));
            check("fready", W'(frame_ready), W'((pos == N-1) && sr));
            if (sr && smp_last) lasts++;
            $display("pos=%0d ready=%0b data=%h last=%0b", pos, sr, smp_data, smp_last);
            step();
            if (sr) pos++;
            if (ph > 4*N + 8) begin
                n_checks++;
                n_fail++;
                $error("FAIL timeout observed=%0d expected=%0d", pos, N);
                break;
            end
        end
        frame_valid = 1'b0;
        exp_fc = (exp_fc + 1) & 16'hFFFF;
        check("one_last", W'(lasts), W'(1));
        #1;
        check("fcnt_after", W'(frame_cnt), W'(exp_fc));
    endtask

    initial begin
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_data  = '0;
        smp_ready   = 1'b0;
        step();
        step();
        #1;
        check("rst_valid", W'(smp_valid), W'(1'b0));
        check("rst_fready", W'(frame_ready), W'(1'b1));
        check("rst_data", smp_data, '0);
        check("rst_index", W'(smp_index), W'(0));
        check("rst_last", W'(smp_last), W'(1'b0));
        check("rst_fcnt", W'(frame_cnt), W'(0));
        @(negedge clk);
        reset = 1'b0;

        // Idle with ready high does nothing.
        smp_ready = 1'b1;
        step();
        step();
        check_idle("idle_ready");

        // Patterned frame, ready held high.
        for (int k = 0; k < N; k++) f_a[W*k +: W] = {32'(k), 32'(100 + k)};
        load(f_a);
        xfer_frame(f_a, 1'b0, 1'b0, '0, -1);
        check_idle("after_f1");

        // Two back-to-back frames, no gap.
        f_b = rand_frame();
        f_c = rand_frame();
        load(f_b);
        xfer_frame(f_b, 1'b0, 1'b1, f_c, -1);
        xfer_frame(f_c, 1'b0, 1'b0, '0, -1);
        check_idle("after_chain");

        // Stalling sink.
        f_b = rand_frame();
        load(f_b);
        xfer_frame(f_b, 1'b1, 1'b0, '0, -1);
        check_idle("after_stall");

        // Frame offered mid-stream is ignored.
        f_c = rand_frame();
        load(f_c);
        xfer_frame(f_c, 1'b1, 1'b0, '0, 5);
        check_idle("after_inject");

        // Reset mid-frame after 10 transfers.
        f_a = rand_frame();
        load(f_a);
        for (int i = 0; i < 10; i++) begin
            smp_ready = 1'b1;
            #1;
            check("pre_rst_data", smp_data, exp_at(f_a, i));
            step();
        end
        reset = 1'b1;
        step();
        reset  = 1'b0;
        exp_fc = 0;
        #1;
        check("mid_rst_data", smp_data, '0);
        check("mid_rst_index", W'(smp_index), W'(0));
        check_idle("mid_rst");
        f_b = rand_frame();
        load(f_b);
        xfer_frame(f_b, 1'b0, 1'b0, '0, -1);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_unloader.md
# fft_frame_unloader

Reader side of the FFT core's parallel output bus. Captures one complete 32-point complex output frame (2048-bit flat vector, sample k at bits [64k+63:64k]) and streams it out one 64-bit sample per cycle over a valid/ready interface. Sits between the FFT core and the result sink (memory writer or host port). Supports back-to-back frames with no idle cycle.

## Interface
- N_PTS, 32, samples per frame; power of two.
- SMP_W, 64, bits per complex sample: real in [SMP_W-1:SMP_W/2], imag in [SMP_W/2-1:0], two's complement.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_valid  input  1  FFT output frame is valid.
- frame_data  input  N_PTS*SMP_W  flat frame; sample k at [SMP_W*k+SMP_W-1 : SMP_W*k].
- frame_ready  output  1  unloader can accept a frame this cycle.
- smp_valid  output  1  smp_data holds a valid sample.
- smp_ready  input  1  sink accepts the sample.
- smp_data  output  SMP_W  current sample.
- smp_index  output  log2(N_PTS)  output position 0..N_PTS-1 of current sample.
- smp_last  output  1  high with the sample at smp_index = N_PTS-1.
- frame_cnt  output  16  completed frames, wraps at 65535 -> 0.

## Operation
- States: IDLE, STREAM.
- IDLE: frame_ready = 1, smp_valid = 0. On frame_valid: latch frame_data into the frame register, cnt <= 0, go STREAM.
- STREAM: smp_valid = 1; smp_data = frame_reg sample selected by cnt (see Configuration); smp_index = cnt; smp_last = (cnt == N_PTS-1).
- Transfer occurs when smp_valid & smp_ready; cnt increments by 1 per transfer; no transfer -> all outputs held stable.
- On the transfer with smp_last: frame_cnt increments; if frame_valid is also high that cycle (frame_ready = 1 then), latch the new frame, cnt <= 0, stay STREAM; otherwise go IDLE.
- frame_ready = (state == IDLE) | (state == STREAM & smp_last & smp_ready). Combinational from state and smp_ready only; never depends on frame_valid.
- frame_data is ignored whenever frame_ready = 0; the frame register is written only on frame_valid & frame_ready.
- Data passes unmodified: no scaling, rounding or sign handling.

## Timing
- Reset values: state IDLE, frame_ready 1, smp_valid 0, smp_data 0, smp_index 0, smp_last 0, frame_cnt 0, frame register 0.
- Latency: frame accepted at edge t -> sample 0 on smp_valid in cycle after t.
- Throughput: N_PTS cycles per frame with smp_ready held high; consecutive frames gapless (sample 31 of frame n followed directly by sample 0 of frame n+1).
- smp_ready low holds the sample indefinitely; smp_data/smp_index/smp_last must not change while smp_valid & !smp_ready.
- Reset asserted mid-frame: next edge forces all reset values; the partial frame is discarded and not counted.
- smp_ready high in IDLE: no effect.

## Configuration
- FFT_UNLOAD_BITREV_EN defined: sample at output position cnt is frame sample bitrev(cnt) over log2(N_PTS) bits, restoring natural order from a bit-reversed FFT output; smp_index still reports cnt.
- Undefined: output position cnt carries frame sample cnt (identity order).

## Structure
- Shared package fft_pkg: N_PTS, SMP_W, LOG2N constants; state enum type; bitrev function on LOG2N-bit indices.
- No sub-module required; sample mux is a single indexed part-select of the frame register.

## Test plan
- Frame with sample k = {32'(k), 32'(100+k)}, smp_ready held 1, macro undefined -> 32 transfers, smp_data = {k, 100+k} at smp_index k, smp_last only at index 31, frame_cnt 0 -> 1, IDLE after.
- Same frame, FFT_UNLOAD_BITREV_EN defined -> position 1 carries sample 16, position 3 carries sample 24, position 31 carries sample 31.
- Two frames, frame_valid held high, smp_ready 1 -> 64 consecutive valid cycles, no gap between index 31 and index 0, frame_cnt = 2.
- smp_ready toggled 1,0,0,1 repeating -> outputs stable during stalls, all 32 samples in order, exactly one smp_last transfer.
- Reset pulsed after 10 transfers -> next cycle smp_valid 0, frame_ready 1, frame_cnt unchanged (0), next frame restarts at index 0.
- frame_valid pulsed with different data mid-stream (index 5) -> ignored; remaining samples come from first frame.
